// File: rtl/pudding_chain_sequencer.sv
// Host-side sequencer for the pudding 128-bit daisychain/state pair: word commands in, chain pin sequence out.
// Build option: define PUDDING_SEQ_AUTOCOMMIT_EN to end every WRITE with a chain->state transfer.
module pudding_chain_sequencer #(
   parameter int CHAIN_LEN = 128,
   parameter int DATA_W    = 8,
   parameter int SHIFT_GAP = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              chain_datum,
   output logic              chain_shift,
   output logic              chain_transfer,
   output logic              chain_dir,
   output logic              chain_stateen,
   input  logic              chain_msb
);

   localparam int WORDS  = CHAIN_LEN / DATA_W;
   localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int WORD_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
   localparam logic [WORD_W-1:0] WORD_LAST = WORD_W'(WORDS - 1);
   localparam logic [3:0]        GAP_LAST  = (SHIFT_GAP > 0) ? 4'(SHIFT_GAP - 1) : 4'd0;

`ifdef PUDDING_SEQ_AUTOCOMMIT_EN
   localparam bit AUTOCOMMIT = 1'b1;
`else
   localparam bit AUTOCOMMIT = 1'b0;
`endif

   typedef enum logic [3:0] {
      IDLE, WR_WAIT, WR_SETUP, WR_PULSE, RD_HOLD, RD_SAMPLE, RD_PULSE, XFER, GAP
   } state_t;

   state_t             state, state_next, ret_state, ret_next, after_bit;
   logic [BIT_W-1:0]   bit_idx, bit_next;
   logic [WORD_W-1:0]  word_idx, word_next;
   logic [3:0]         gap_cnt, gap_next;
   logic [DATA_W-1:0]  wr_word, rd_word;
   logic               last_bit, last_word, xfer_dir, datum_next;

   // Handshakes: a word/command moves on a cycle where valid & ready are both high;
   // valid may not depend on ready, and rd_valid holds rd_data stable until taken.
   assign cmd_ready = (state == IDLE) && chain_stateen;
   assign wr_ready  = (state == WR_WAIT);
   assign busy      = (state != IDLE);
   assign last_bit  = (bit_idx == BIT_LAST);
   assign last_word = (word_idx == WORD_LAST);

   always_comb begin
      state_next = state;
      ret_next   = ret_state;
      bit_next   = bit_idx;
      word_next  = word_idx;
      gap_next   = gap_cnt;
      xfer_dir   = !(state == IDLE && cmd_op == 2'd3);
      datum_next = 1'b0;

      // Where the sequence goes once the current bit's pulse (and gap) is done
      if (!last_bit)
         after_bit = (state == RD_PULSE) ? RD_SAMPLE : WR_SETUP;
      else if (!last_word)
         after_bit = (state == RD_PULSE) ? RD_HOLD : WR_WAIT;
      else if (state == WR_PULSE && AUTOCOMMIT)
         after_bit = XFER;
      else
         after_bit = IDLE;

      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               case (cmd_op)
                  2'd0:    state_next = WR_WAIT;
                  2'd1:    state_next = RD_HOLD;
                  default: state_next = XFER;
               endcase
            end
         end
         WR_WAIT:   if (wr_valid) state_next = WR_SETUP;
         WR_SETUP:  state_next = WR_PULSE;
         RD_HOLD:   if (!(rd_valid && !rd_ready)) state_next = RD_SAMPLE;
         RD_SAMPLE: state_next = RD_PULSE;
         WR_PULSE, RD_PULSE: begin
            bit_next = last_bit ? '0 : bit_idx + 1'b1;
            if (last_bit) word_next = last_word ? '0 : word_idx + 1'b1;
            if (SHIFT_GAP == 0) begin
               state_next = after_bit;
            end else begin
               state_next = GAP;
               ret_next   = after_bit;
               gap_next   = 4'd0;
            end
         end
         GAP: begin
            if (gap_cnt == GAP_LAST) state_next = ret_state;
            else gap_next = gap_cnt + 4'd1;
         end
         XFER:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      case (state_next)
         WR_SETUP:            datum_next = (state == WR_WAIT) ? wr_data[bit_next] : wr_word[bit_next];
         WR_PULSE:            datum_next = chain_datum;
         RD_SAMPLE, RD_PULSE: datum_next = chain_msb;
         default:             datum_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state          <= IDLE;
         ret_state      <= IDLE;
         bit_idx        <= '0;
         word_idx       <= '0;
         gap_cnt        <= 4'd0;
         wr_word        <= '0;
         rd_word        <= '0;
         rd_data        <= '0;
         rd_valid       <= 1'b0;
         chain_datum    <= 1'b0;
         chain_shift    <= 1'b0;
         chain_transfer <= 1'b0;
         chain_dir      <= 1'b0;
         chain_stateen  <= 1'b0;
      end else begin
         state     <= state_next;
         ret_state <= ret_next;
         bit_idx   <= bit_next;
         word_idx  <= word_next;
         gap_cnt   <= gap_next;
         if (state == WR_WAIT && wr_valid) wr_word <= wr_data;
         if (state == RD_SAMPLE) rd_word[bit_idx] <= chain_msb;
         // The last sample is already in rd_word by the time its pulse cycle runs
         if (state == RD_PULSE && last_bit) begin
            rd_data  <= rd_word;
            rd_valid <= 1'b1;
         end else if (rd_valid && rd_ready) begin
            rd_valid <= 1'b0;
         end
         chain_datum    <= datum_next;
         chain_shift    <= (state_next == WR_PULSE) || (state_next == RD_PULSE);
         chain_transfer <= (state_next == XFER);
         chain_dir      <= (state_next == XFER) && xfer_dir;
         chain_stateen  <= 1'b1;
      end
   end

endmodule
